// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg
// Constants shared by the ID/EX operand stage and the ALU control decoder.
// Contents:
//   - ALU_* : 4-bit ALU operation codes driven to the ALU.
//   - aluop_e : 2-bit ALU class encodings from main control.
//   - FUNCT_* : R-type funct field values that the ALU control decodes.
package id_ex_operand_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,  // lw / sw / addi
    ALUOP_SUB   = 2'b01,  // beq / bne
    ALUOP_RTYPE = 2'b10,  // operation chosen by funct
    ALUOP_OR    = 2'b11   // ori
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/id_ex_operand_stage_alu_control.sv
// id_ex_operand_stage_alu_control
// Purely combinational ALU control decoder. It maps the main-control ALU class
// and the funct field to a 4-bit ALU operation. It is also usable by a
// single-cycle core.
// Ports:
//   aluop   in  2  ALU class from main control
//   funct   in  6  instruction funct field
//   alu_op  out 4  ALU operation code
//   illegal out 1  R-type with an unsupported funct (alu_op falls back to add)
module id_ex_operand_stage_alu_control
  import id_ex_operand_stage_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_op = ALU_SUB;
      ALUOP_OR:  alu_op = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          FUNCT_NOR: alu_op = ALU_NOR;
          default: begin
            alu_op  = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// This is the ID/EX pipeline register of the 5-stage MIPS core. It captures the
// decoded operands and control fields. It forwards results from MEM and WB
// into the ALU operands. It decodes the ALU operation.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   stall, flush          hold the stage / replace the captured instruction by a bubble
//   id_*                  decoded operands and control from ID
//   mem_regwrite/rd/result  forwarding source from EX/MEM
//   wb_regwrite/rd/result   forwarding source from MEM/WB
//   alu_a, alu_b, alu_op  ALU inputs
//   ex_store_data         forwarded rt value used as store data
//   ex_dest, ex_regwrite  destination index and qualified write enable
//   ex_valid, ex_illegal  stage occupancy and unsupported-funct flag
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_regwrite,
  output logic              ex_valid,
  output logic              ex_illegal
);

  logic              valid_q;
  logic              regwrite_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [5:0]        funct_q;
  logic [1:0]        aluop_q;
  logic              alusrc_q;
  logic              regdst_q;

  // A flush writes a fully cleared bubble. This keeps the bubble fields
  // deterministic and equal to the reset values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
      aluop_q    <= '0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      funct_q    <= '0;
      aluop_q    <= '0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
    end else if (!stall) begin
      valid_q    <= id_valid;
      regwrite_q <= id_regwrite;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_q      <= id_imm;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rd_q       <= id_rd;
      funct_q    <= id_funct;
      aluop_q    <= id_aluop;
      alusrc_q   <= id_alusrc;
      regdst_q   <= id_regdst;
    end
  end

  // Forwarding uses the live mem_*/wb_* inputs, so it keeps tracking the
  // downstream stages while this stage is stalled. r0 is hard-wired to zero
  // and is never forwarded.
  logic mem_hit_rs, wb_hit_rs, mem_hit_rt, wb_hit_rt;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  assign mem_hit_rs = mem_regwrite && (mem_rd == rs_q) && (rs_q != '0);
  assign wb_hit_rs  = wb_regwrite  && (wb_rd  == rs_q) && (rs_q != '0);
  assign mem_hit_rt = mem_regwrite && (mem_rd == rt_q) && (rt_q != '0);
  assign wb_hit_rt  = wb_regwrite  && (wb_rd  == rt_q) && (rt_q != '0);

  // MEM holds the younger result, so it takes priority over WB.
  assign fwd_rs = mem_hit_rs ? mem_result : (wb_hit_rs ? wb_result : rs_data_q);
  assign fwd_rt = mem_hit_rt ? mem_result : (wb_hit_rt ? wb_result : rt_data_q);

  assign alu_a         = fwd_rs;
  assign alu_b         = alusrc_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_dest       = regdst_q ? rd_q : rt_q;
  assign ex_regwrite   = regwrite_q & valid_q;
  assign ex_valid      = valid_q;

  logic illegal;

  id_ex_operand_stage_alu_control u_alu_control (
    .aluop   (aluop_q),
    .funct   (funct_q),
    .alu_op  (alu_op),
    .illegal (illegal)
  );

  assign ex_illegal = illegal & valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluop;
  logic        id_alusrc, id_regdst, id_regwrite;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_op;
  logic [4:0]  ex_dest;
  logic        ex_regwrite, ex_valid, ex_illegal;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] a, b, store;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic        rw, v, ill;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_regwrite(id_regwrite), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_result(wb_result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
    .ex_valid(ex_valid), .ex_illegal(ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] store, input logic [3:0] op, input logic [4:0] dest,
                      input logic rw, input logic v, input logic ill);
    exp_t e;
    e.tag = tag; e.a = a; e.b = b; e.store = store; e.op = op;
    e.dest = dest; e.rw = rw; e.v = v; e.ill = ill;
    sb.push_back(e);
  endtask

  // One capturing edge, then compare the outputs with the oldest expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".alu_a"},       alu_a,         e.a);
      chk({e.tag, ".alu_b"},       alu_b,         e.b);
      chk({e.tag, ".store"},       ex_store_data, e.store);
      chk({e.tag, ".alu_op"},      32'(alu_op),   32'(e.op));
      chk({e.tag, ".dest"},        32'(ex_dest),  32'(e.dest));
      chk({e.tag, ".regwrite"},    32'(ex_regwrite), 32'(e.rw));
      chk({e.tag, ".valid"},       32'(ex_valid), 32'(e.v));
      chk({e.tag, ".illegal"},     32'(ex_illegal), 32'(e.ill));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".alu_a"},    alu_a, 32'd0);
    chk({tag, ".alu_b"},    alu_b, 32'd0);
    chk({tag, ".store"},    ex_store_data, 32'd0);
    chk({tag, ".alu_op"},   32'(alu_op), 32'd2);
    chk({tag, ".dest"},     32'(ex_dest), 32'd0);
    chk({tag, ".regwrite"}, 32'(ex_regwrite), 32'd0);
    chk({tag, ".valid"},    32'(ex_valid), 32'd0);
    chk({tag, ".illegal"},  32'(ex_illegal), 32'd0);
  endtask

  task automatic set_id(input logic v, input logic [31:0] rs_d, input logic [31:0] rt_d,
                        input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] funct, input logic [1:0] aluop,
                        input logic alusrc, input logic regdst, input logic regwrite);
    id_valid = v; id_rs_data = rs_d; id_rt_data = rt_d; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_funct = funct; id_aluop = aluop;
    id_alusrc = alusrc; id_regdst = regdst; id_regwrite = regwrite;
  endtask

  logic [5:0] functs [6];
  logic [3:0] ops    [6];

  initial begin
    functs[0] = 6'b100000; ops[0] = 4'b0010;
    functs[1] = 6'b100010; ops[1] = 4'b0110;
    functs[2] = 6'b100100; ops[2] = 4'b0000;
    functs[3] = 6'b100101; ops[3] = 4'b0001;
    functs[4] = 6'b101010; ops[4] = 4'b0111;
    functs[5] = 6'b100111; ops[5] = 4'b1100;

    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
    wb_regwrite = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // R-type add
    set_id(1'b1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd4, 6'b100000, 2'b10, 1'b0, 1'b1, 1'b1);
    push("add", 32'd5, 32'd7, 32'd7, 4'b0010, 5'd4, 1'b1, 1'b1, 1'b0);
    step();

    // Forwarding priority on rs=3
    set_id(1'b1, 32'h11, 32'h22, 32'd0, 5'd3, 5'd0, 5'd0, 6'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    push("fwd_base", 32'h11, 32'h22, 32'h22, 4'b0010, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    mem_regwrite = 1'b1; mem_rd = 5'd3; mem_result = 32'hAA;
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
    #1 chk("fwd_mem_over_wb", alu_a, 32'hAA);
    chk("fwd_rt0_not_fwd", ex_store_data, 32'h22);
    mem_regwrite = 1'b0;
    #1 chk("fwd_wb", alu_a, 32'hBB);
    wb_regwrite = 1'b0;
    #1 chk("fwd_none", alu_a, 32'h11);

    // r0 guard and rt forwarding
    set_id(1'b1, 32'd0, 32'h33, 32'd0, 5'd0, 5'd5, 5'd0, 6'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    mem_rd = 5'd0; wb_rd = 5'd0;
    push("r0_load", 32'd0, 32'h33, 32'h33, 4'b0010, 5'd5, 1'b0, 1'b1, 1'b0);
    step();
    mem_regwrite = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
    #1 chk("r0_guard", alu_a, 32'd0);
    mem_rd = 5'd5;
    #1 chk("fwd_rt_alu_b", alu_b, 32'hFF);
    chk("fwd_rt_store", ex_store_data, 32'hFF);
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_result = 32'h77;
    #1 chk("fwd_rt_mem_prio", alu_b, 32'hFF);
    mem_regwrite = 1'b0;
    #1 chk("fwd_rt_wb", ex_store_data, 32'h77);
    wb_regwrite = 1'b0; mem_rd = 5'd0; wb_rd = 5'd0;

    // Stall holds, forwarding stays live, then flush beats stall
    set_id(1'b1, 32'd9, 32'd4, 32'd0, 5'd6, 5'd7, 5'd8, 6'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    push("sub", 32'd9, 32'd4, 32'd4, 4'b0110, 5'd7, 1'b0, 1'b1, 1'b0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h123 + 32'(i), 32'h456, 32'h1, 5'd10, 5'd11, 5'd12, 6'b100101, 2'b10,
             1'b1, 1'b1, 1'b1);
      push("stall", 32'd9, 32'd4, 32'd4, 4'b0110, 5'd7, 1'b0, 1'b1, 1'b0);
      step();
    end
    mem_regwrite = 1'b1; mem_rd = 5'd6; mem_result = 32'h55;
    #1 chk("stall_fwd_live", alu_a, 32'h55);
    mem_regwrite = 1'b0; mem_rd = 5'd0;
    flush = 1'b1;
    push("flush_stall", 32'd0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    stall = 1'b0; flush = 1'b0;

    // Decode sweep
    for (int i = 0; i < 6; i++) begin
      set_id(1'b1, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'(i + 3), functs[i], 2'b10,
             1'b0, 1'b1, 1'b1);
      push($sformatf("rtype%0d", i), 32'd1, 32'd2, 32'd2, ops[i], 5'(i + 3), 1'b1, 1'b1, 1'b0);
      step();
    end
    set_id(1'b1, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd20, 6'b000000, 2'b10, 1'b0, 1'b1, 1'b1);
    push("illegal", 32'd1, 32'd2, 32'd2, 4'b0010, 5'd20, 1'b1, 1'b1, 1'b1);
    step();
    flush = 1'b1;
    push("illegal_flush", 32'd0, 32'd0, 32'd0, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    set_id(1'b1, 32'd3, 32'd4, 32'd8, 5'd1, 5'd2, 5'd0, 6'b000000, 2'b11, 1'b1, 1'b0, 1'b1);
    push("ori", 32'd3, 32'd8, 32'd4, 4'b0001, 5'd2, 1'b1, 1'b1, 1'b0);
    step();

    // Bubble from id_valid=0: fields load, write and illegal are suppressed
    set_id(1'b0, 32'd6, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 6'b000000, 2'b10, 1'b0, 1'b1, 1'b1);
    push("id_bubble", 32'd6, 32'd7, 32'd7, 4'b0010, 5'd3, 1'b0, 1'b0, 1'b0);
    step();

    // Immediate path then async reset mid-cycle
    set_id(1'b1, 32'h10, 32'h44, 32'hFFFFFFFC, 5'd1, 5'd9, 5'd3, 6'b000000, 2'b00,
           1'b1, 1'b0, 1'b1);
    push("imm", 32'h10, 32'hFFFFFFFC, 32'h44, 4'b0010, 5'd9, 1'b1, 1'b1, 1'b0);
    step();
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
